fusion_blend: RTL and testbench
===============================

Name: fusion_blend

Overview:
- Stage directly downstream of the HSSIM selector in the LRF fusion pipeline.
- Consumes the Gaussian-blurred per-pixel decision weight (del_in, 0..255) and blends the old fused image with the new input image: fused = w*new + (1-w)*old.
- Holds the image pixel streams in an internal alignment delay line so they match the HSSIM output latency.
- Emits a valid/ready output stream with end-of-frame marking, and back-pressures the whole upstream pipeline through a global stall.

Parameters:
PIXELS_PER_BEAT, 16, pixels per beat, 8 bits each
IMAGE_DIM, 512, image width = height in pixels
ALIGN_DLY, 8, advance cycles between a pixel beat entering and its del_in arriving (>=1)
DATA_WIDTH, 8*PIXELS_PER_BEAT, beat width

Ports:
clk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_valid  in  1  old_img/new_img beat present this cycle
old_img  in  DATA_WIDTH  previous fused image beat, pixel j at [j*8+:8]
new_img  in  DATA_WIDTH  new input image beat
del_in  in  DATA_WIDTH  blurred weight from HSSIM, aligned ALIGN_DLY advances after its pixels
stall  out  1  global pipeline hold, shared with HSSIM and all upstream stages
m_data  out  DATA_WIDTH  fused beat
m_valid  out  1  m_data valid
m_last  out  1  last beat of frame
m_ready  in  1  downstream accepts
frame_done  out  1  one-cycle pulse when the last beat of a frame transfers

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values:
  - Outputs: m_valid=0, m_last=0, frame_done=0, stall=0.
  - Internal: all delay-line valid bits=0, beat counter=0.
  - Data registers: no reset required; m_data is don't-care while m_valid=0.
- Stall and advance:
  - stall = m_valid & ~m_ready (combinational).
  - adv = ~stall.
  - All internal registers update only when adv=1; when stall=1 every register holds.
- Delay line:
  - ALIGN_DLY-deep shift register of {s_valid, old_img, new_img}, shifted on adv.
  - Entry at the tail pairs with del_in sampled on the same adv cycle.
- Weight mapping, per pixel: wp = w + w[7], 9 bits. So 0->0, 127->127, 128->129, 255->256.
- Stage A, registered on adv:
  - pa = wp*new (17 bits)
  - pb = (256-wp)*old (17 bits)
  - valid bit carried forward.
- Stage B, registered on adv:
  - fused = (pa + pb + 128) >> 8, 8 bits.
  - Never exceeds 255; no saturation logic needed.
  - m_valid <= stage A valid.
- Latency: a beat entering with s_valid=1 on adv cycle t appears on m_data/m_valid after exactly ALIGN_DLY+2 adv cycles.
- Cycles with s_valid=0 produce bubbles (m_valid=0) at the same offset. Bubbles never assert stall.
- Beat counter:
  - BEATS = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT.
  - Increments on each transfer (m_valid & m_ready).
  - m_last = m_valid & (cnt == BEATS-1).
  - On transfer of the last beat: counter wraps to 0 and frame_done pulses high for that single cycle.
- Simultaneous events:
  - A transfer and new stage-B data in the same cycle are both honoured: no loss, no duplication.
  - m_ready rising while stall=1 releases the pipeline on that same cycle.
- Reset mid-frame:
  - All valids cleared immediately.
  - Beat counter returns to 0.
  - In-flight beats are discarded.
  - The first post-reset valid beat is beat 0 of a new frame.
- m_data, m_valid and m_last stay stable while m_valid & ~m_ready.

Test Plan:
1. Reset, then continuous s_valid=1, m_ready=1, del_in=255, new=0xC8, old=0x10 -> first m_valid exactly ALIGN_DLY+2 cycles after the first beat; every pixel is 0xC8.
2. del_in=0, new=0xC8, old=0x10 -> every pixel is 0x10.
3. del_in=128, new=200, old=100 -> (129*200 + 127*100 + 128) >> 8 = 150. Also del_in=1, new=255, old=0 -> 1.
4. Hold m_ready=0 for 5 cycles mid-stream:
   - stall=1 on exactly those cycles while m_valid=1.
   - m_data holds.
   - After release the output sequence equals the no-stall reference with no gaps, drops or repeats.
5. IMAGE_DIM=16, PIXELS_PER_BEAT=16 (BEATS=16), two full frames:
   - m_last high on output beats 15 and 31 only.
   - frame_done pulses on those transfer cycles.
   - Counter wraps.
6. Random s_valid gaps plus an aresetn pulse mid-frame:
   - Outputs clear asynchronously.
   - The next frame's m_last falls on its 16th transferred beat.

Source files
------------

// File: rtl/fusion_blend_if.sv
// Stream bundle for the fusion blend stage.
// Carries the pixel and weight inputs, the fused output stream and the global stall.
// The slave modport is the blend stage. The master modport is its environment:
// the upstream pixel/HSSIM side and the downstream consumer.
interface fusion_blend_if #(
  parameter int DATA_WIDTH = 128
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] old_img;
  logic [DATA_WIDTH-1:0] new_img;
  logic [DATA_WIDTH-1:0] del_in;
  logic                  stall;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_last;
  logic                  m_ready;
  logic                  frame_done;

  modport master (
    output s_valid, old_img, new_img, del_in, m_ready,
    input  stall, m_data, m_valid, m_last, frame_done
  );

  modport slave (
    input  s_valid, old_img, new_img, del_in, m_ready,
    output stall, m_data, m_valid, m_last, frame_done
  );
endinterface

// File: rtl/fusion_blend.sv
// Fusion blend stage: fused = w*new + (1-w)*old, computed per 8-bit pixel.
// The image beats travel through an alignment delay line so that they meet their HSSIM weight.
// The blend itself is two register stages: products first, then the rounded sum.
// Any unaccepted output freezes the whole pipeline and raises the global stall.
module fusion_blend #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int ALIGN_DLY       = 8,
  parameter int DATA_WIDTH      = 8*PIXELS_PER_BEAT
) (
  input logic           clk_i,
  input logic           aresetn_i,
  fusion_blend_if.slave bus
);

  localparam int BEATS = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS-1);

  logic                  adv;
  logic                  xfer;
  logic                  mLast;

  logic [ALIGN_DLY-1:0]  dlyVld_q;
  logic [DATA_WIDTH-1:0] dlyOld_q [ALIGN_DLY];
  logic [DATA_WIDTH-1:0] dlyNew_q [ALIGN_DLY];

  logic [8:0]            wp       [PIXELS_PER_BEAT];
  logic [16:0]           pa_d     [PIXELS_PER_BEAT];
  logic [16:0]           pb_d     [PIXELS_PER_BEAT];
  logic [16:0]           pa_q     [PIXELS_PER_BEAT];
  logic [16:0]           pb_q     [PIXELS_PER_BEAT];
  logic                  aVld_q;

  logic [DATA_WIDTH-1:0] fused_d;
  logic [DATA_WIDTH-1:0] mData_q;
  logic                  mValid_q;

  logic [CNT_W-1:0]      cnt_d;
  logic [CNT_W-1:0]      cnt_q;

  // A beat that is held back downstream freezes everything. Bubbles never stall.
  assign bus.stall      = mValid_q & ~bus.m_ready;
  assign adv            = ~bus.stall;
  assign xfer           = mValid_q & bus.m_ready;
  assign mLast          = mValid_q & (cnt_q == LAST_BEAT);
  assign bus.m_data     = mData_q;
  assign bus.m_valid    = mValid_q;
  assign bus.m_last     = mLast;
  assign bus.frame_done = mLast & bus.m_ready;

  // Per-pixel weight mapping and stage A products, using the delay-line tail and del_in.
  // Stage B uses the rounded sum of the stage A products.
  // Mapping 255 to 256 makes a full weight select the new pixel exactly.
  always_comb begin
    fused_d = '0;
    for (int j = 0; j < PIXELS_PER_BEAT; j++) begin
      wp[j]   = {1'b0, bus.del_in[j*8 +: 8]} + 9'(bus.del_in[j*8+7]);
      pa_d[j] = 17'(wp[j]) * 17'(dlyNew_q[ALIGN_DLY-1][j*8 +: 8]);
      pb_d[j] = 17'(9'd256 - wp[j]) * 17'(dlyOld_q[ALIGN_DLY-1][j*8 +: 8]);
      fused_d[j*8 +: 8] = 8'((pa_q[j] + pb_q[j] + 17'd128) >> 8);
    end
  end

  // Valid bits of the delay line and both blend stages.
  // They clear on reset, which drops in-flight beats, and shift only on adv.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      dlyVld_q <= '0;
      aVld_q   <= 1'b0;
      mValid_q <= 1'b0;
    end else if (adv) begin
      dlyVld_q[0] <= bus.s_valid;
      for (int i = 1; i < ALIGN_DLY; i++) begin
        dlyVld_q[i] <= dlyVld_q[i-1];
      end
      aVld_q   <= dlyVld_q[ALIGN_DLY-1];
      mValid_q <= aVld_q;
    end
  end

  // Data path registers. They need no reset because they are qualified by the valid bits above.
  always_ff @(posedge clk_i) begin
    if (adv) begin
      dlyOld_q[0] <= bus.old_img;
      dlyNew_q[0] <= bus.new_img;
      for (int i = 1; i < ALIGN_DLY; i++) begin
        dlyOld_q[i] <= dlyOld_q[i-1];
        dlyNew_q[i] <= dlyNew_q[i-1];
      end
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      mData_q <= fused_d;
    end
  end

  // Beat-in-frame counter. It steps on each accepted beat and wraps after the last beat of a frame.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer) begin
      cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register. It restarts at beat 0 on reset.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fusion_blend.sv
// Directed bench for fusion_blend using a 16x16 image, so each frame is 16 beats.
// A weight pipe of ALIGN_DLY entries supplies del_in ALIGN_DLY advances after its pixels.
// A scoreboard of expected fused pixels is checked on every output transfer.
module tb_fusion_blend;

  localparam int PPB   = 16;
  localparam int DIM   = 16;
  localparam int A     = 8;
  localparam int DW    = 8*PPB;
  localparam int BEATS = DIM*DIM/PPB;

  logic clk = 1'b0;
  logic aresetn;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0] wPipe [A];
  logic [7:0] expQ [$];
  int         bcnt;
  int         xferCount;
  int         firstLastIdx;

  fusion_blend_if #(.DATA_WIDTH(DW)) bus ();

  fusion_blend #(
    .PIXELS_PER_BEAT(PPB),
    .IMAGE_DIM      (DIM),
    .ALIGN_DLY      (A),
    .DATA_WIDTH     (DW)
  ) dut (
    .clk_i    (clk),
    .aresetn_i(aresetn),
    .bus      (bus.slave)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Reference blend using the mapped weight: wp = w + w[7], result rounded to nearest.
  function automatic logic [7:0] blend(input logic [7:0] w, input logic [7:0] o, input logic [7:0] n);
    int wp;
    wp = int'(w) + int'(w[7]);
    return 8'((wp*int'(n) + (256-wp)*int'(o) + 128) >> 8);
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the output side just before a rising edge: scoreboard, m_last and frame_done.
  task automatic sampleOutputs();
    logic [7:0] e;
    if (bus.m_valid && bus.m_ready) begin
      checkOutput("beatExpected", DW'(expQ.size() != 0), DW'(1));
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("mData", bus.m_data, {PPB{e}});
      end
      checkOutput("mLast", DW'(bus.m_last), DW'(bcnt == BEATS-1));
      checkOutput("frameDone", DW'(bus.frame_done), DW'(bcnt == BEATS-1));
      xferCount++;
      if (bcnt == BEATS-1 && firstLastIdx == 0) firstLastIdx = xferCount;
      bcnt = (bcnt + 1) % BEATS;
    end else begin
      checkOutput("frameDoneIdle", DW'(bus.frame_done), DW'(0));
      if (!bus.m_valid) checkOutput("mLastIdle", DW'(bus.m_last), DW'(0));
    end
  endtask

  // Presents one upstream beat, retrying while stalled, and ends at the next falling edge.
  task automatic applyStimulus(input bit sv, input logic [7:0] o, input logic [7:0] n, input logic [7:0] w);
    bit accepted;
    int tries;
    accepted = 1'b0;
    tries    = 0;
    while (!accepted) begin
      bus.s_valid = sv;
      bus.old_img = {PPB{o}};
      bus.new_img = {PPB{n}};
      bus.del_in  = {PPB{wPipe[A-1]}};
      #1;
      sampleOutputs();
      accepted = !bus.stall;
      @(posedge clk);
      if (accepted) begin
        for (int i = A-1; i > 0; i--) wPipe[i] = wPipe[i-1];
        wPipe[0] = w;
        if (sv) expQ.push_back(blend(w, o, n));
      end
      @(negedge clk);
      tries++;
      if (!accepted && tries > 20) begin
        checkOutput("advTimeout", DW'(bus.stall), DW'(0));
        break;
      end
    end
  endtask

  task automatic clearModel();
    expQ.delete();
    bcnt         = 0;
    xferCount    = 0;
    firstLastIdx = 0;
    for (int i = 0; i < A; i++) wPipe[i] = 8'h00;
  endtask

  initial begin
    int sent;
    bit sv;
    bus.s_valid = 1'b0;
    bus.old_img = '0;
    bus.new_img = '0;
    bus.del_in  = '0;
    bus.m_ready = 1'b0;
    aresetn     = 1'b0;
    clearModel();

    // Reset state. m_ready low must not raise stall while nothing is valid.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstMValid", DW'(bus.m_valid), DW'(0));
    checkOutput("rstMLast", DW'(bus.m_last), DW'(0));
    checkOutput("rstFrameDone", DW'(bus.frame_done), DW'(0));
    checkOutput("rstStall", DW'(bus.stall), DW'(0));
    aresetn     = 1'b1;
    bus.m_ready = 1'b1;

    // Full weight selects the new pixel. The first output appears after A+2 edges.
    for (int k = 1; k <= A+2; k++) begin
      applyStimulus(1'b1, 8'h10, 8'hC8, 8'hFF);
      checkOutput($sformatf("latency%0d", k), DW'(bus.m_valid), DW'(k == A+2));
    end
    checkOutput("pixW255", bus.m_data, {PPB{8'hC8}});

    // Zero weight selects the old pixel.
    for (int k = 0; k < A+2; k++) applyStimulus(1'b1, 8'h10, 8'hC8, 8'h00);
    checkOutput("pixW0", bus.m_data, {PPB{8'h10}});

    // Weight 128 maps to 129: (129*200 + 127*100 + 128) >> 8 = 150.
    for (int k = 0; k < A+2; k++) applyStimulus(1'b1, 8'd100, 8'd200, 8'd128);
    checkOutput("pixW128", bus.m_data, {PPB{8'd150}});
    // Weight 1 with new=255 and old=0 gives 1.
    for (int k = 0; k < A+2; k++) applyStimulus(1'b1, 8'd0, 8'd255, 8'd1);
    checkOutput("pixW1", bus.m_data, {PPB{8'd1}});

    // Varied beats, then hold m_ready low for 5 cycles.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(i*20), 8'(255-i*7), 8'(i*40));
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("stallOn%0d", i), DW'(bus.stall), DW'(1));
      checkOutput($sformatf("holdValid%0d", i), DW'(bus.m_valid), DW'(1));
      checkOutput($sformatf("holdData%0d", i), bus.m_data, {PPB{expQ[0]}});
      checkOutput($sformatf("holdFrameDone%0d", i), DW'(bus.frame_done), DW'(0));
      @(posedge clk);
      @(negedge clk);
    end
    bus.m_ready = 1'b1;
    #1;
    checkOutput("stallRelease", DW'(bus.stall), DW'(0));
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 8'(i*9), 8'(i*13+5), 8'(i*37));
    for (int i = 0; i < A+4; i++) applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("drainedNoStall", DW'(expQ.size()), DW'(0));

    // Random gaps, then an asynchronous reset while a beat is held back.
    for (int i = 0; i < 7; i++) applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < A+3; i++) applyStimulus(1'b1, 8'h33, 8'h77, 8'h40);
    bus.m_ready = 1'b0;
    #1;
    checkOutput("preRstStall", DW'(bus.stall), DW'(1));
    #1;
    aresetn = 1'b0;
    #1;
    checkOutput("asyncMValid", DW'(bus.m_valid), DW'(0));
    checkOutput("asyncStall", DW'(bus.stall), DW'(0));
    checkOutput("asyncMLast", DW'(bus.m_last), DW'(0));
    @(negedge clk);
    aresetn     = 1'b1;
    bus.m_ready = 1'b1;
    clearModel();

    // New frame with random gaps. Its m_last must land on the 16th transfer.
    sent = 0;
    for (int i = 0; i < 200 && sent < 20; i++) begin
      sv = ($urandom_range(0, 3) != 0);
      applyStimulus(sv, 8'($urandom), 8'($urandom), 8'($urandom));
      if (sv) sent++;
    end
    for (int i = 0; i < A+4; i++) applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("lastAt16", DW'(firstLastIdx), DW'(16));
    checkOutput("drainedAfterRst", DW'(expQ.size()), DW'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
